// File: rtl/irq_pending_latch.sv
// Sixteen synchronized, sticky interrupt-pending bits feed an external priority encoder.
// An IDLE/CAPT/HOLD presenter sits behind the encoder. Define IRQ_OVERRUN_EN to add ovr_clr/ovr_o.
module irq_pending_lane #(
    parameter bit LEVEL_MODE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic clr,
    output logic set_ev,
    output logic pend
);
    logic s1, s2, s3;

    generate
        if (LEVEL_MODE) begin : g_level
            assign set_ev = s2;
        end else begin : g_edge
            assign set_ev = s2 & ~s3;
        end
    endgenerate

    // A set on the same edge as the clear wins, so a repeat request is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            pend <= 1'b0;
        end else begin
            s1   <= req;
            s2   <= s1;
            s3   <= s2;
            pend <= set_ev | (pend & ~clr);
        end
    end
endmodule

module irq_pending_latch #(
    parameter int LEVEL_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] mask,
    output logic [15:0] pend_o,
    output logic        enc_en_o,
    input  logic [3:0]  enc_y,
    output logic        irq_valid,
    output logic [3:0]  irq_id,
    input  logic        irq_ack
`ifdef IRQ_OVERRUN_EN
    ,
    input  logic        ovr_clr,
    output logic [15:0] ovr_o
`endif
);
    localparam int NUM_LANES = 16;

    typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

    state_t               state;
    logic [NUM_LANES-1:0] pending, set_ev, clr;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        irq_pending_lane #(.LEVEL_MODE(LEVEL_MODE != 0)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (req[i]),
            .clr    (clr[i]),
            .set_ev (set_ev[i]),
            .pend   (pending[i])
        );
    end

    assign pend_o   = pending & ~mask;
    assign enc_en_o = |pend_o;
    assign clr      = (state == HOLD && irq_ack) ? ({{(NUM_LANES-1){1'b0}}, 1'b1} << irq_id)
                                                 : '0;

    // Once the FSM leaves IDLE it is committed; mask changes only affect the next pick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= 4'b0000;
        end else begin
            case (state)
                IDLE: if (enc_en_o) state <= CAPT;
                CAPT: begin
                    irq_id    <= enc_y;
                    irq_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (irq_ack) begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef IRQ_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_o <= '0;
        else        ovr_o <= (ovr_clr ? '0 : ovr_o) | (set_ev & pending & ~clr);
    end
`endif
endmodule

// File: doc/irq_pending_latch.md
IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 Parameter LEVEL_MODE, default 0: 0 means a rising edge on req sets pending; 1 means a synchronized high level sets pending.
REQ-002 clk  in  1  single clock; all flops SHALL be on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req  in  16  asynchronous request lines; bit 15 is the highest priority.
REQ-005 mask  in  16  synchronous; 1 blocks the bit from arbitration only and does not block latching.
REQ-006 pend_o  out  16  pending & ~mask; drives the downstream 16-to-4 priority encoder input.
REQ-007 enc_en_o  out  1  OR-reduction of pend_o; drives the encoder enable.
REQ-008 enc_y  in  4  encoder output code for the highest set bit of pend_o.
REQ-009 irq_valid  out  1  interrupt presented to the consumer.
REQ-010 irq_id  out  4  captured index; SHALL be stable while irq_valid=1.
REQ-011 irq_ack  in  1  consumer acknowledge; ignored unless irq_valid=1.

Function
REQ-012 Each req bit SHALL pass through a 2-flop synchronizer (s1, s2), plus one history flop (s3).
REQ-013 Set condition per bit: s2 & ~s3 when LEVEL_MODE=0; s2 when LEVEL_MODE=1.
REQ-014 Latency: req high before edge k, low before k-1 → pending bit set at edge k+2.
REQ-015 The internal 16-bit pending register SHALL be sticky until cleared by an acknowledge.
REQ-016 pend_o and enc_en_o SHALL be combinational from the pending register and mask.
REQ-017 FSM states and transitions:
- IDLE → CAPT when enc_en_o=1.
- CAPT: irq_id <= enc_y; → HOLD.
- HOLD: irq_valid=1; on irq_ack → IDLE.
REQ-018 irq_valid SHALL be 1 in HOLD only, registered with no combinational path from inputs.
REQ-019 At the ack edge in HOLD, pending[irq_id] SHALL clear.
REQ-020 If the set condition for the same bit occurs in the same cycle as its clear, the set SHALL win and the bit stays pending.
REQ-021 Masking or new higher-priority requests during CAPT/HOLD SHALL NOT change irq_id or drop irq_valid.
REQ-022 If all pending bits become masked during CAPT, the FSM SHALL still capture enc_y and present it.
REQ-023 Back-to-back: after an ack, the next request SHALL be presented with irq_valid high 2 cycles after the ack edge (IDLE, CAPT, HOLD).
REQ-024 Outputs are fixed combinationally as a function of mask, so unmasked pend_o always reflects state and never goes to Z.

Reset
REQ-025 rst_n low SHALL asynchronously force the following to their reset values:
- s1/s2/s3 = 0, pending = 0, state = IDLE.
- irq_valid = 0, irq_id = 4'b0000.
- ovr_o = 0 (when present).
REQ-026 A req held high through reset release SHALL produce one set event 2 edges after release.
REQ-027 Reset asserted in HOLD SHALL drop irq_valid immediately and discard the captured request.

Configuration
REQ-028 Macro IRQ_OVERRUN_EN, when defined, SHALL add the following:
- ports ovr_clr (in, 1) and ovr_o (out, 16).
- ovr_o[n] sets when bit n's set condition occurs while pending[n]=1 and it is not being cleared.
- ovr_o[n] is sticky and is cleared by ovr_clr=1 for one cycle; a set in the same cycle as ovr_clr wins.
REQ-029 When IRQ_OVERRUN_EN is undefined, the ports and logic SHALL be absent and repeat events SHALL be silently merged.

Verification
REQ-030 Single request with LEVEL_MODE=0, mask=0:
- Stimulus: req[5] rises before edge 10.
- Response: pend_o=16'h0020 after edge 12; irq_valid=1 with irq_id=4'd5 after edge 14; ack at edge 16 → pend_o=0 and irq_valid=0.
REQ-031 Priority:
- Stimulus: req[3] and req[12] rise together.
- Response: irq_id=12 presented first; after ack, irq_id=3 with irq_valid high 2 cycles after the ack edge.
REQ-032 Masking:
- Stimulus: mask=16'h0100, req[8] rises.
- Response: pending set internally, pend_o=0, irq_valid stays 0; mask→0 → irq_id=8 presented.
REQ-033 Same-cycle set and clear:
- Stimulus: a req[7] set event coincides with the ack of irq_id=7.
- Response: bit 7 stays pending and is re-presented; with IRQ_OVERRUN_EN, ovr_o=0.
REQ-034 Overrun:
- Stimulus: with IRQ_OVERRUN_EN, req[2] pulses twice before ack.
- Response: ovr_o=16'h0004 until ovr_clr.
REQ-035 Reset in HOLD:
- Stimulus: irq_id=9 presented, rst_n low mid-cycle.
- Response: irq_valid=0 and pend_o=0 immediately without a clock edge.
